// File: rtl/keypad_pkg.sv
// Shared types, key constants and the row/column to key-code encoder
// for the 3x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'h0;

  // One-hot row plus column bits to phone-pad code; the lowest set column wins.
  function automatic logic [3:0] key_encode(input logic [3:0] row, input logic [2:0] col);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    r = row[1] ? 2'd1 : (row[2] ? 2'd2 : (row[3] ? 2'd3 : 2'd0));
    c = col[0] ? 2'd0 : (col[1] ? 2'd1 : 2'd2);
    if (col == 3'b000) begin
      code = KEY_NONE;
    end else if (r == 2'd3) begin
      code = (c == 2'd0) ? KEY_STAR : ((c == 2'd1) ? 4'h0 : KEY_HASH);
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_key_fifo.sv
// Small synchronous FIFO of 4-bit key codes; a pop and a push in the same
// cycle are both honoured even when full, and the head reads KEY_NONE when empty.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic       full,
  output logic       empty,
  output logic [3:0] head
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] DEPTH_N = CNTW'(DEPTH);
  localparam logic [AW-1:0]   LAST_N  = AW'(DEPTH - 1);

  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_pop, do_push;

  assign full  = (count_q == DEPTH_N);
  assign empty = (count_q == {CNTW{1'b0}});
  assign head  = empty ? KEY_NONE : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_N) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_N) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNTW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never visible while empty, so no reset.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad row scanner with column debounce, key-code FIFO, overflow flag and
// a fixed-length interrupt pulse for each accepted key.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4,
  parameter int INTR_LEN = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] COL,
  input  logic       KEY_RD,
  input  logic       OVF_CLR,
  output logic [3:0] ROW,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       INTR,
  output logic       OVF
);

  import keypad_pkg::state_e;
  import keypad_pkg::key_encode;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int IW = $clog2(INTR_LEN + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE);
  localparam logic [IW-1:0] INTR_N   = IW'(INTR_LEN);

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    col_meta_q, scol_q;
  logic [3:0]    row_q, row_d, row_rot;
  logic [3:0]    cand_q, cand_d, scode;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] intr_cnt_q, intr_cnt_d;
  logic          intr_q, intr_d, ovf_q, ovf_d;
  logic          tick, same_key, push, drop;
  logic          fifo_full, fifo_empty;

  // Prescaler, scan/debounce FSM, interrupt counter and overflow flag.
  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? {DW{1'b0}} : div_q + DW'(1);
    scode    = key_encode(row_q, scol_q);
    same_key = (scol_q != 3'b000) && (scode == cand_q);
    row_rot  = {row_q[2:0], row_q[3]};
    state_d  = state_q;
    row_d    = row_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (tick) begin
      case (state_q)
        keypad_pkg::SCAN: begin
          if (scol_q == 3'b000) begin
            row_d = row_rot;
          end else begin
            cand_d = scode;
            if (DEB_N == CW'(1)) begin
              push    = 1'b1;
              state_d = keypad_pkg::RELEASE;
              cnt_d   = {CW{1'b0}};
            end else begin
              state_d = keypad_pkg::DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        keypad_pkg::DEBOUNCE: begin
          if (same_key && (cnt_q + CW'(1) == DEB_N)) begin
            push    = 1'b1;
            state_d = keypad_pkg::RELEASE;
            cnt_d   = {CW{1'b0}};
          end else if (same_key) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = keypad_pkg::SCAN;
            row_d   = row_rot;
            cnt_d   = {CW{1'b0}};
          end
        end
        keypad_pkg::RELEASE: begin
          if ((scol_q == 3'b000) && (cnt_q + CW'(1) == DEB_N)) begin
            state_d = keypad_pkg::SCAN;
            row_d   = row_rot;
            cnt_d   = {CW{1'b0}};
          end else if (scol_q == 3'b000) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = {CW{1'b0}};
          end
        end
        default: begin
          state_d = keypad_pkg::SCAN;
          row_d   = 4'b0001;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      push = 1'b0;
    end

    // A full FIFO still accepts a push when the MCU pops in the same cycle.
    drop = push & fifo_full & ~KEY_RD;
    if (push && !drop) begin
      intr_cnt_d = INTR_N;
    end else if (intr_cnt_q != {IW{1'b0}}) begin
      intr_cnt_d = intr_cnt_q - IW'(1);
    end else begin
      intr_cnt_d = intr_cnt_q;
    end
    intr_d = (intr_cnt_d != {IW{1'b0}});
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // All controller state, including the two-flop column synchronizer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= keypad_pkg::SCAN;
      div_q      <= {DW{1'b0}};
      col_meta_q <= 3'b000;
      scol_q     <= 3'b000;
      row_q      <= 4'b0001;
      cand_q     <= 4'h0;
      cnt_q      <= {CW{1'b0}};
      intr_cnt_q <= {IW{1'b0}};
      intr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      col_meta_q <= COL;
      scol_q     <= col_meta_q;
      row_q      <= row_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      intr_cnt_q <= intr_cnt_d;
      intr_q     <= intr_d;
      ovf_q      <= ovf_d;
    end
  end

  key_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push & ~drop),
    .pop  (KEY_RD),
    .din  (cand_d),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (KEY_CODE)
  );

  assign ROW       = row_q;
  assign KEY_VALID = ~fifo_empty;
  assign INTR      = intr_q;
  assign OVF       = ovf_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the Basys3 3x4 phone keypad. It drives the row strobes, samples and debounces the columns, and encodes each accepted press into a 4-bit key code. Codes are buffered in a small FIFO, and the block signals the MCU with a fixed-length interrupt pulse. It replaces the free-running scan/press logic and the separate interrupt FSM with one controller that the MCU drains through a read strobe.

## Interface
- SCAN_DIV, 100000: CLK cycles per row dwell (scan tick period); minimum 2.
- DEBOUNCE, 4: consecutive identical tick samples needed to accept a press or a release; minimum 1.
- DEPTH, 4: FIFO entries; power of two.
- INTR_LEN, 2: CLK cycles INTR stays high per accepted key.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- COL  in  3  keypad columns, active-high, asynchronous; COL[0] left, COL[2] right.
- KEY_RD  in  1  MCU pop strobe, one cycle; ignored when empty.
- OVF_CLR  in  1  clears OVF.
- ROW  out  4  one-hot row drive, ROW[0] top row.
- KEY_CODE  out  4  FIFO head code; 4'h0 when empty.
- KEY_VALID  out  1  FIFO not empty.
- INTR  out  1  interrupt pulse to MCU.
- OVF  out  1  sticky: a key was dropped because the FIFO was full.

## Operation
- Reset values:
  - ROW=4'b0001.
  - KEY_CODE=0, KEY_VALID=0, INTR=0, OVF=0.
  - FIFO empty, prescaler=0, state SCAN, counters 0.
- COL passes through a 2-flop synchronizer; all decisions use the synchronized value scol.
- Prescaler counts 0..SCAN_DIV-1. tick is high in the cycle the count equals SCAN_DIV-1, then the count wraps to 0.
- Key map, code = f(row, col): row0 gives 1,2,3; row1 gives 4,5,6; row2 gives 7,8,9; row3 gives *=4'hA, 0=4'h0, #=4'hB.
- Several columns high at once: the lowest column index wins.
- States:
  - SCAN, on tick:
    - scol==0: rotate ROW left (4'b1000 wraps to 4'b0001).
    - Otherwise: latch cand=code, set cnt=1, go to DEBOUNCE. ROW is held.
  - DEBOUNCE, on tick:
    - Encoded scol equals cand: cnt++. When cnt reaches DEBOUNCE, push cand and go to RELEASE with cnt=0.
    - Otherwise (different key or none): go to SCAN and rotate ROW.
  - DEBOUNCE=1 pushes on the same tick that detects the key.
  - RELEASE, on tick:
    - scol==0: cnt++. When cnt reaches DEBOUNCE, go to SCAN and rotate ROW.
    - Otherwise: cnt=0.
  - ROW is held during RELEASE.
- FIFO:
  - Push when not full, or when full with KEY_RD in the same cycle (pop then push; nothing is dropped).
  - Push while full without KEY_RD: the code is discarded and OVF is set.
  - KEY_RD pops the head; KEY_RD while empty has no effect.
  - OVF_CLR and a set event in the same cycle: the set wins.
- INTR: every successful push loads a counter with INTR_LEN, and INTR is high while the counter is nonzero. A new push during the pulse reloads the counter, extending the pulse. A dropped push raises no INTR.

## Timing
- COL to scol latency: 2 cycles.
- Accepting a push takes DEBOUNCE ticks with the same key held.
- KEY_VALID and INTR rise in the cycle after the accepting tick edge.
- KEY_CODE is valid while KEY_VALID is high. It updates the cycle after a KEY_RD edge, or the cycle after a push into an empty FIFO.
- Minimum press-to-press spacing: 2·DEBOUNCE ticks.
- Reset asserted mid-operation (any state, non-empty FIFO, active INTR): every output takes its reset value on the next edge and queued keys are lost.

## Structure
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, RELEASE}
  - constants KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_NONE=4'h0
  - function key_encode(row, col)
- Sub-module key_fifo: synchronous FIFO, DEPTH parameter, 4-bit data, push/pop/full/empty/head, same CLK/RST.
- The prescaler, synchronizer, FSM and INTR counter live in keypad_scan_ctrl.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, INTR_LEN=2.
- Reset, no key held: ROW steps 0001→0010→0100→1000→0001, one step every 4 cycles. KEY_VALID=0, INTR=0.
- Hold COL=3'b010 while ROW=0010 for more than 3 ticks → KEY_CODE=4'h5, KEY_VALID=1, INTR high 2 cycles. ROW is frozen until COL=0 for 3 ticks.
- Row 3: COL=001 gives 4'hA, COL=100 gives 4'hB. Row 3 with COL=011 gives 4'hA (lowest column wins).
- Bounce: COL high for 2 ticks then low → no push, ROW resumes rotating.
- Press 5 keys without KEY_RD → 4 codes stored and OVF=1. Four KEY_RD pulses return the codes in press order, then KEY_VALID=0. OVF_CLR clears OVF.
- RST while in RELEASE with 2 codes queued → ROW=0001, KEY_VALID=0, OVF=0, INTR=0 on the next cycle.
